// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared definitions for the bus-side control blocks: bus/index widths,
// sequencer state encoding and the request validity rule.
package bus_xfer_ctrl_pkg;

    localparam int BUS_W = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_LATCH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        state_e state;
        logic   imm_oe;
    } dbg_t;

    // A destination must exist; a register source must exist and differ from dst.
    function automatic logic req_ok(input logic [IDX_W-1:0] src,
                                    input logic [IDX_W-1:0] dst,
                                    input logic             imm_en,
                                    input int               nreg);
        logic ok;
        ok = int'(dst) < nreg;
        if (!imm_en) ok = ok && (int'(src) < nreg) && (src != dst);
        return ok;
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request/status bundle between a transfer issuer (master) and the
// bus_xfer_ctrl sequencer (slave), plus the one-hot register enables.
interface bus_xfer_ctrl_if
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int NREG = 8
);
    // Handshake: req is sampled only while the sequencer is idle (busy=0);
    // there is no ready, a req seen while busy is dropped, not queued. done
    // pulses once per accepted req, with err when the request was rejected.
    logic             req;
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
    logic             imm_en;
    logic [BUS_W-1:0] imm;
    logic             busy;
    logic             done;
    logic             err;
    logic [NREG-1:0]  outflag;
    logic [NREG-1:0]  inflag;

    modport master (
        output req, src, dst, imm_en, imm,
        input  busy, done, err, outflag, inflag
    );

    modport slave (
        input  req, src, dst, imm_en, imm,
        output busy, done, err, outflag, inflag
    );

endinterface

// File: rtl/bus_xfer_ctrl_settle_timer.sv
// Bus settle down-counter: load, decrement to zero and hold, zero flag.
module settle_timer
    import bus_xfer_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             RESET,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-transfer sequencer: drives a source (register or immediate) onto
// the bus, lets it settle, pulses the destination latch, then holds.
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int NREG   = 8,
    parameter int SETTLE = 2
)(
    input  logic                 clk,
    input  logic                 RESET,
    bus_xfer_ctrl_if.slave       bus,
    output wire  [BUS_W-1:0]     imm_bus,
    output dbg_t                 dbg_o
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic             imm_en_q, imm_en_d;
    logic [BUS_W-1:0] imm_q, imm_d;
    logic             rej_q, rej_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             imm_oe_q, imm_oe_d;
    logic [NREG-1:0]  outflag_q, outflag_d;
    logic [NREG-1:0]  inflag_q, inflag_d;

    logic             tmr_load;
    logic             tmr_zero;
    logic             driving;

    // DRIVE lasts SETTLE cycles: loaded with SETTLE-1 on entry, leaves at zero.
    assign tmr_load = (state_q == ST_IDLE) && (state_d == ST_DRIVE);

    settle_timer u_settle (
        .clk        (clk),
        .RESET      (RESET),
        .load_i     (tmr_load),
        .dec_i      (state_q == ST_DRIVE),
        .load_val_i (CNT_W'(SETTLE - 1)),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        imm_en_d = imm_en_q;
        imm_d    = imm_q;
        rej_d    = rej_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    src_d    = bus.src;
                    dst_d    = bus.dst;
                    imm_en_d = bus.imm_en;
                    imm_d    = bus.imm;
                    rej_d    = !req_ok(bus.src, bus.dst, bus.imm_en, NREG);
                    state_d  = rej_d ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE: if (tmr_zero) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        driving   = (state_d == ST_DRIVE) || (state_d == ST_LATCH) || (state_d == ST_HOLD);
        outflag_d = '0;
        inflag_d  = '0;
        for (int i = 0; i < NREG; i++) begin
            outflag_d[i] = driving && !imm_en_d && (src_d == IDX_W'(i));
            inflag_d[i]  = (state_d == ST_LATCH) && (dst_d == IDX_W'(i));
        end
        imm_oe_d = driving && imm_en_d;
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_DONE) && rej_d;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            src_q     <= '0;
            dst_q     <= '0;
            imm_en_q  <= 1'b0;
            imm_q     <= '0;
            rej_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            imm_oe_q  <= 1'b0;
            outflag_q <= '0;
            inflag_q  <= '0;
        end else begin
            src_q     <= src_d;
            dst_q     <= dst_d;
            imm_en_q  <= imm_en_d;
            imm_q     <= imm_d;
            rej_q     <= rej_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            imm_oe_q  <= imm_oe_d;
            outflag_q <= outflag_d;
            inflag_q  <= inflag_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.outflag = outflag_q;
    assign bus.inflag  = inflag_q;
    assign imm_bus     = imm_oe_q ? imm_q : {BUS_W{1'bz}};
    assign dbg_o       = {state_q, imm_oe_q};

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: cycle timeline model, register-file
// model on the bus, and directed transfers with literal expectations.
module tb_bus_xfer_ctrl;
    import bus_xfer_ctrl_pkg::*;

    localparam int NREG   = 6;
    localparam int SETTLE = 2;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             err;
        logic             imm_oe;
        logic [BUS_W-1:0] imm;
        logic [NREG-1:0]  outflag;
        logic [NREG-1:0]  inflag;
    } exp_t;
    localparam exp_t IDLE_REC = '0;

    logic             clk   = 1'b0;
    logic             RESET = 1'b1;
    wire  [BUS_W-1:0] imm_bus;
    dbg_t             dbg;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t_acc  = 0;
    int done_cnt, err_cnt, flag_cyc, out02_cnt, in_at, imm_cyc, done_cyc;
    exp_t             exp_q[$];
    logic [BUS_W-1:0] regs[NREG];

    bus_xfer_ctrl_if #(.NREG(NREG)) bus_if ();

    bus_xfer_ctrl #(.NREG(NREG), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .RESET   (RESET),
        .bus     (bus_if),
        .imm_bus (imm_bus),
        .dbg_o   (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- model: expected per-cycle transfer timeline ----------------
    function automatic void push_transfer(input logic [2:0] s, input logic [2:0] d,
                                          input logic ie, input logic [7:0] im);
        exp_t e;
        bit   rej;
        rej = (int'(d) >= NREG) || (!ie && ((int'(s) >= NREG) || (s == d)));
        if (rej) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int k = 0; k < SETTLE + 2; k++) begin
                e = '0;
                e.busy   = 1'b1;
                e.imm_oe = ie;
                e.imm    = ie ? im : 8'h00;
                if (!ie) e.outflag[s] = 1'b1;
                if (k == SETTLE) e.inflag[d] = 1'b1;
                exp_q.push_back(e);
            end
            e = '0; e.busy = 1'b1; e.done = 1'b1;
            exp_q.push_back(e);
        end
        exp_q.push_back(IDLE_REC);
    endfunction

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!RESET) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = IDLE_REC;
            check("cycle_outputs",
                  {bus_if.busy, bus_if.done, bus_if.err, dbg.imm_oe, bus_if.outflag, bus_if.inflag},
                  {e.busy, e.done, e.err, e.imm_oe, e.outflag, e.inflag});
            if (e.imm_oe) check("imm_bus", imm_bus, e.imm);
        end
    end

    // ---------------- monitor + register-file model on the bus ----------------
    always @(negedge clk) begin
        logic [BUS_W-1:0] bus_val;
        if (!RESET) begin
            if (bus_if.outflag != '0 || bus_if.inflag != '0) flag_cyc++;
            if (bus_if.outflag == 6'h02) out02_cnt++;
            if (bus_if.inflag == 6'h10) in_at = out02_cnt;
            if (dbg.imm_oe) imm_cyc++;
            if (bus_if.done) begin done_cnt++; done_cyc = cyc; end
            if (bus_if.err) err_cnt++;
            bus_val = 8'h00;
            if (dbg.imm_oe) bus_val = imm_bus;
            for (int j = 0; j < NREG; j++) if (bus_if.outflag[j]) bus_val = bus_val | regs[j];
            for (int i = 0; i < NREG; i++) if (bus_if.inflag[i]) regs[i] = bus_val;
        end
    end

    // ---------------- drivers ----------------
    task automatic clr_mon();
        done_cnt = 0; err_cnt = 0; flag_cyc = 0; out02_cnt = 0;
        in_at = -1; imm_cyc = 0; done_cyc = -1;
    endtask

    task automatic drive_cycle(input logic r, input logic [2:0] s, input logic [2:0] d,
                               input logic ie, input logic [7:0] im);
        @(negedge clk); #1;
        bus_if.req = r; bus_if.src = s; bus_if.dst = d; bus_if.imm_en = ie; bus_if.imm = im;
        if (r && exp_q.size() == 0) begin
            t_acc = cyc;
            push_transfer(s, d, ie, im);
        end
    endtask

    // Idle cycles scramble the operand inputs; captured operands must not follow.
    task automatic drive_idle();
        drive_cycle(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    endtask

    task automatic finish_xfer(input int want, input string name);
        int n;
        n = 0;
        while (done_cnt < want && n < 40) begin drive_idle(); n++; end
        checks++;
        if (done_cnt < want) begin
            errors++;
            $display("FAIL %s_done_timeout: done pulses %0d expected %0d", name, done_cnt, want);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin drive_idle(); n++; end
        drive_idle();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bus_if.req = 1'b0; bus_if.src = '0; bus_if.dst = '0; bus_if.imm_en = 1'b0; bus_if.imm = '0;
        for (int i = 0; i < NREG; i++) regs[i] = 8'(8'h30 + i);
        clr_mon();

        RESET = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_done_err", {bus_if.done, bus_if.err}, 2'b00);
        check("rst_flags", {bus_if.outflag, bus_if.inflag}, 12'h000);
        check("rst_state", dbg.state, ST_IDLE);
        check("rst_imm_oe", dbg.imm_oe, 1'b0);
        RESET = 1'b0;
        repeat (2) drive_idle();

        // move R1 -> R4
        clr_mon();
        drive_cycle(1'b1, 3'd1, 3'd4, 1'b0, 8'h00);
        finish_xfer(1, "mv1_4");
        check("mv1_4_latency", done_cyc - t_acc, 5);
        check("mv1_4_outflag_cycles", out02_cnt, 4);
        check("mv1_4_inflag_pos", in_at, 3);
        check("mv1_4_err", err_cnt, 0);
        check("mv1_4_R4", regs[4], 8'h31);

        // load immediate A5 -> R0 (src field ignored)
        clr_mon();
        drive_cycle(1'b1, 3'd7, 3'd0, 1'b1, 8'hA5);
        finish_xfer(1, "imm_0");
        check("imm_0_latency", done_cyc - t_acc, 5);
        check("imm_0_drive_cycles", imm_cyc, 4);
        check("imm_0_R0", regs[0], 8'hA5);
        check("imm_0_no_flags_besides_latch", flag_cyc, 1);

        // rejected requests: src==dst, dst out of range (7 and 6), src out of range
        clr_mon();
        drive_cycle(1'b1, 3'd3, 3'd3, 1'b0, 8'h00);
        finish_xfer(1, "rej_same");
        check("rej_same_latency", done_cyc - t_acc, 1);
        check("rej_same_err", err_cnt, 1);
        check("rej_same_flags", flag_cyc, 0);

        clr_mon();
        drive_cycle(1'b1, 3'd2, 3'd7, 1'b0, 8'h00);
        finish_xfer(1, "rej_dst7");
        drive_cycle(1'b1, 3'd2, 3'd6, 1'b1, 8'h5A);
        finish_xfer(2, "rej_dst6");
        drive_cycle(1'b1, 3'd6, 3'd1, 1'b0, 8'h00);
        finish_xfer(3, "rej_src6");
        check("rej_range_err", err_cnt, 3);
        check("rej_range_flags", flag_cyc, 0);

        // second req during LATCH is ignored
        clr_mon();
        drive_cycle(1'b1, 3'd2, 3'd5, 1'b0, 8'h00);
        repeat (SETTLE) drive_idle();
        drive_cycle(1'b1, 3'd0, 3'd1, 1'b0, 8'h00);
        finish_xfer(1, "mv2_5");
        repeat (4) drive_idle();
        check("mv2_5_done_pulses", done_cnt, 1);
        check("mv2_5_R5", regs[5], 8'h32);
        check("mv2_5_R1_untouched", regs[1], 8'h31);

        // req held through DONE: accepted again on the following IDLE cycle
        clr_mon();
        for (int k = 0; k < SETTLE + 5; k++) drive_cycle(1'b1, 3'd0, 3'd2, 1'b0, 8'h00);
        finish_xfer(2, "held");
        check("held_done_pulses", done_cnt, 2);
        check("held_R2", regs[2], 8'hA5);

        // reset mid-DRIVE: flags drop without a clock edge, no done pulse
        clr_mon();
        drive_cycle(1'b1, 3'd3, 3'd1, 1'b0, 8'h00);
        drive_idle();
        #2;
        check("abort_pre_outflag", bus_if.outflag, 6'h08);
        RESET = 1'b1;
        exp_q.delete();
        #1;
        check("abort_outflag", bus_if.outflag, 6'h00);
        check("abort_inflag", bus_if.inflag, 6'h00);
        check("abort_busy", bus_if.busy, 1'b0);
        @(negedge clk); #1;
        RESET = 1'b0;
        repeat (4) drive_idle();
        check("abort_no_done", done_cnt, 0);
        check("abort_R1_untouched", regs[1], 8'h31);

        drive_cycle(1'b1, 3'd3, 3'd1, 1'b0, 8'h00);
        finish_xfer(1, "after_abort");
        check("after_abort_latency", done_cyc - t_acc, 5);
        check("after_abort_R1", regs[1], 8'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
